// File: rtl/fp_dot_product_sequencer_if.sv
// Signal bundle for fp_dot_product_sequencer: command, chunk stream, dot-product unit bus, result.
// master = the sequencer itself; slave = its environment (source, unit, consumer).
interface fp_dot_product_sequencer_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 7,
  parameter int MAX_LEN    = 256
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // command
  logic                        start;
  logic [LEN_W-1:0]            len;
  logic                        busy;

  // operand chunk stream
  logic [WIDTH*NUM_INPUTS-1:0] chunk_a;
  logic [WIDTH*NUM_INPUTS-1:0] chunk_b;
  logic                        chunk_valid;
  logic                        chunk_ready;

  // dot-product unit
  logic [WIDTH*NUM_INPUTS-1:0] dp_a;
  logic [WIDTH*NUM_INPUTS-1:0] dp_b;
  logic [WIDTH-1:0]            dp_c;
  logic [NUM_INPUTS-1:0]       dp_enable;
  logic                        dp_ready;
  logic [WIDTH-1:0]            dp_out;
  logic                        dp_valid;

  // scalar result
  logic [WIDTH-1:0]            result;
  logic                        result_valid;
  logic                        result_ready;

  modport master (
    input  start, len, chunk_a, chunk_b, chunk_valid, dp_out, dp_valid, result_ready,
    output busy, chunk_ready, dp_a, dp_b, dp_c, dp_enable, dp_ready, result, result_valid
  );

  modport slave (
    output start, len, chunk_a, chunk_b, chunk_valid, dp_out, dp_valid, result_ready,
    input  busy, chunk_ready, dp_a, dp_b, dp_c, dp_enable, dp_ready, result, result_valid
  );
endinterface

// File: rtl/fp_dot_product_sequencer.sv
// Splits a long FP dot product into NUM_INPUTS-lane chunks, chaining each partial into dp_c.
// Optional WAIT watchdog with timeout_err port: define DP_SEQ_TIMEOUT_EN.
module fp_dot_product_sequencer #(
  parameter int WIDTH          = 32,
  parameter int NUM_INPUTS     = 7,
  parameter int MAX_LEN        = 256
`ifdef DP_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic clk,
  input  logic rst,
`ifdef DP_SEQ_TIMEOUT_EN
  output logic timeout_err,
`endif
  fp_dot_product_sequencer_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state;
  logic [LEN_W-1:0]      chunks_left;
  logic [LEN_W-1:0]      rem;
  logic [WIDTH-1:0]      partial;

`ifdef DP_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]      wait_cnt;
`endif

  // Command decode: saturated length, chunk count and tail-lane count.
  logic [LEN_W-1:0]      len_sat;
  logic [LEN_W:0]        len_round;
  logic [LEN_W-1:0]      chunk_total;
  logic [LEN_W-1:0]      len_rem;
  logic                  last_chunk;
  logic [NUM_INPUTS-1:0] lane_mask;

  always_comb begin
    len_sat     = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
    len_round   = {1'b0, len_sat} + (LEN_W + 1)'(NUM_INPUTS - 1);
    chunk_total = LEN_W'(len_round / (LEN_W + 1)'(NUM_INPUTS));
    len_rem     = len_sat % LEN_W'(NUM_INPUTS);
  end

  assign last_chunk = (chunks_left == LEN_W'(1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lane_mask = '1;
    if (last_chunk && (rem != '0)) lane_mask = NUM_INPUTS'((1 << rem) - 1);
  end

  // NOTE: state and registered outputs use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      chunks_left      <= '0;
      rem              <= '0;
      partial          <= '0;
      bus.busy         <= 1'b0;
      bus.chunk_ready  <= 1'b0;
      bus.dp_a         <= '0;
      bus.dp_b         <= '0;
      bus.dp_c         <= '0;
      bus.dp_enable    <= '0;
      bus.dp_ready     <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
`ifdef DP_SEQ_TIMEOUT_EN
      timeout_err      <= 1'b0;
      wait_cnt         <= '0;
`endif
    end else begin
      bus.dp_ready <= 1'b0;
`ifdef DP_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.busy    <= 1'b1;
            partial     <= '0;
            chunks_left <= chunk_total;
            rem         <= len_rem;
            if (len_sat == '0) begin
              bus.result       <= '0;
              bus.result_valid <= 1'b1;
              state            <= S_DONE;
            end else begin
              bus.chunk_ready <= 1'b1;
              state           <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (bus.chunk_valid) begin
            bus.chunk_ready <= 1'b0;
            bus.dp_a        <= bus.chunk_a;
            bus.dp_b        <= bus.chunk_b;
            bus.dp_c        <= partial;
            bus.dp_enable   <= lane_mask;
            bus.dp_ready    <= 1'b1;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
`ifdef DP_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.dp_valid) begin
            partial     <= bus.dp_out;
            chunks_left <= chunks_left - LEN_W'(1);
            if (last_chunk) begin
              bus.result       <= bus.dp_out;
              bus.result_valid <= 1'b1;
              state            <= S_DONE;
            end else begin
              bus.chunk_ready <= 1'b1;
              state           <= S_FETCH;
            end
          end
`ifdef DP_SEQ_TIMEOUT_EN
          // Unit never answered: abandon the operation without producing a result.
          else if (wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
`endif
        end

        S_DONE: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
            state            <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_dot_product_sequencer.sv
// Self-checking bench: vector table, hand-written corner sequences and random ops
// checked against an integer-sum reference, with a behavioural 19-cycle dot-product unit.
module tb_fp_dot_product_sequencer;
  localparam int WIDTH   = 32;
  localparam int NI      = 7;
  localparam int MAX_LEN = 256;
  localparam int LAT     = 19;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int VMAX    = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_dot_product_sequencer_if #(.WIDTH(WIDTH), .NUM_INPUTS(NI), .MAX_LEN(MAX_LEN)) bus ();
`ifdef DP_SEQ_TIMEOUT_EN
  logic timeout_err;
`endif

  fp_dot_product_sequencer #(.WIDTH(WIDTH), .NUM_INPUTS(NI), .MAX_LEN(MAX_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DP_SEQ_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact int -> float32 for |v| < 2**24.
  function automatic logic [31:0] i2f(input int v);
    logic        s;
    logic [31:0] mag;
    int          msb;
    if (v == 0) return 32'h0;
    s   = (v < 0);
    mag = s ? 32'(-v) : 32'(v);
    msb = 0;
    for (int k = 0; k < 24; k++) if (mag[k]) msb = k;
    mag = mag << (23 - msb);
    return {s, 8'(127 + msb), mag[22:0]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural dot-product unit and issue log.
  int                 issues   = 0;
  int                 cr_count = 0;
  int                 pend     = 0;
  bit                 dp_hold  = 1'b0;
  logic [31:0]        pend_res;
  logic [31:0]        c_log[$];
  logic [NI-1:0]      en_log[$];

  always @(negedge clk) begin : dp_model
    real acc;
    bus.dp_valid = 1'b0;
    if (bus.chunk_ready) cr_count++;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.dp_valid = 1'b1;
        bus.dp_out   = pend_res;
      end
    end
    if (bus.dp_ready && !rst) begin
      issues++;
      c_log.push_back(bus.dp_c);
      en_log.push_back(bus.dp_enable);
      acc = f2r(bus.dp_c);
      for (int l = 0; l < NI; l++)
        if (bus.dp_enable[l]) acc += f2r(bus.dp_a[l*WIDTH +: WIDTH]) * f2r(bus.dp_b[l*WIDTH +: WIDTH]);
      if (!dp_hold) begin
        pend_res = r2f(acc);
        pend     = LAT;
      end
    end
  end

  // Operand vectors for the current operation.
  int va[VMAX];
  int vb[VMAX];

  function automatic logic [WIDTH*NI-1:0] build_chunk(input int c, input int sat, input bit is_a);
    logic [WIDTH*NI-1:0] v;
    for (int l = 0; l < NI; l++) begin
      int idx = c * NI + l;
      if (idx < sat) v[l*WIDTH +: WIDTH] = i2f(is_a ? va[idx] : vb[idx]);
      else           v[l*WIDTH +: WIDTH] = $urandom;
    end
    return v;
  endfunction

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_chunk(input logic [WIDTH*NI-1:0] a, input logic [WIDTH*NI-1:0] b);
    int k = 0;
    bus.chunk_a     = a;
    bus.chunk_b     = b;
    bus.chunk_valid = 1'b1;
    while (!bus.chunk_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("chunk_accept_timeout", 0, 1);
    @(negedge clk);
    bus.chunk_valid = 1'b0;
  endtask

  task automatic wait_result();
    int k = 0;
    while (!bus.result_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("result_timeout", 0, 1);
  endtask

  task automatic run_op(input int n, input int gap_max, output logic [31:0] res);
    int sat = (n > MAX_LEN) ? MAX_LEN : n;
    int nch = (sat + NI - 1) / NI;
    do_start(n);
    for (int c = 0; c < nch; c++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_chunk(build_chunk(c, sat, 1'b1), build_chunk(c, sat, 1'b0));
    end
    wait_result();
    res = bus.result;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  typedef struct {
    int            len;
    int            a;
    int            b;
    int            n_issue;
    logic [NI-1:0] last_en;
    logic [31:0]   last_c;
    logic [31:0]   res;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [31:0] res, r0;
    int          base_iss, base_cr, sum, n;
    bit          stable;

    vecs[0] = '{7,   1, 2, 1,  7'h7F, 32'h00000000, 32'h41600000};
    vecs[1] = '{10,  1, 1, 2,  7'h07, 32'h40E00000, 32'h41200000};
    vecs[2] = '{0,   1, 1, 0,  7'h00, 32'h00000000, 32'h00000000};
    vecs[3] = '{1,   3, 2, 1,  7'h01, 32'h00000000, 32'h40C00000};
    vecs[4] = '{14,  1, 1, 2,  7'h7F, 32'h40E00000, 32'h41600000};
    vecs[5] = '{300, 1, 1, 37, 7'h0F, 32'h437C0000, 32'h43800000};

    bus.start = 1'b0; bus.len = '0; bus.chunk_valid = 1'b0;
    bus.chunk_a = '0; bus.chunk_b = '0; bus.result_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",         bus.busy, 0);
    check("rst_chunk_ready",  bus.chunk_ready, 0);
    check("rst_dp_ready",     bus.dp_ready, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_result",       bus.result, 0);
    check("rst_dp_a",         64'(bus.dp_a[63:0]), 0);
    check("rst_dp_c",         bus.dp_c, 0);
    check("rst_dp_enable",    bus.dp_enable, 0);
`ifdef DP_SEQ_TIMEOUT_EN
    check("rst_timeout_err",  timeout_err, 0);
`endif
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < VMAX; k++) begin
        va[k] = vecs[i].a;
        vb[k] = vecs[i].b;
      end
      base_iss = issues;
      base_cr  = cr_count;
      run_op(vecs[i].len, 2, res);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_issues", i), issues - base_iss, vecs[i].n_issue);
      check($sformatf("vec%0d_busy_after", i), bus.busy, 0);
      if (vecs[i].n_issue > 0) begin
        check($sformatf("vec%0d_first_c", i), c_log[base_iss], 0);
        check($sformatf("vec%0d_last_en", i), en_log[issues - 1], vecs[i].last_en);
        check($sformatf("vec%0d_last_c", i), c_log[issues - 1], vecs[i].last_c);
      end else begin
        check($sformatf("vec%0d_no_chunk_ready", i), cr_count - base_cr, 0);
      end
    end

    // Stalled chunk source, stalled consumer, start during DONE ignored.
    for (int k = 0; k < VMAX; k++) begin va[k] = 1; vb[k] = 2; end
    base_iss = issues;
    do_start(7);
    repeat (5) @(negedge clk);
    check("stall_no_issue", issues - base_iss, 0);
    check("stall_busy", bus.busy, 1);
    check("stall_chunk_ready", bus.chunk_ready, 1);
    send_chunk(build_chunk(0, 7, 1'b1), build_chunk(0, 7, 1'b0));
    wait_result();
    r0 = bus.result;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 3);
      bus.len   = LEN_W'(14);
      @(negedge clk);
      if (bus.result !== r0 || !bus.result_valid) stable = 1'b0;
    end
    bus.start = 1'b0;
    check("hold_result", r0, 32'h41600000);
    check("hold_stable", stable, 1);
    bus.result_ready = 1'b1;
    bus.start        = 1'b1;
    bus.len          = LEN_W'(7);
    @(negedge clk);
    bus.result_ready = 1'b0;
    bus.start        = 1'b0;
    check("done_exit_busy", bus.busy, 0);
    check("done_exit_valid", bus.result_valid, 0);
    repeat (3) @(negedge clk);
    check("done_start_ignored_busy", bus.busy, 0);
    check("done_start_ignored_issue", issues - base_iss, 1);

    // Reset while waiting on the unit, then a stale strobe.
    base_iss = issues;
    do_start(7);
    send_chunk(build_chunk(0, 7, 1'b1), build_chunk(0, 7, 1'b0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_chunk_ready", bus.chunk_ready, 0);
    check("abort_dp_c", bus.dp_c, 0);
    check("abort_dp_enable", bus.dp_enable, 0);
    repeat (LAT + 10) @(negedge clk);
    check("stale_busy", bus.busy, 0);
    check("stale_result_valid", bus.result_valid, 0);
    run_op(7, 1, res);
    check("after_abort_result", res, 32'h41600000);

`ifdef DP_SEQ_TIMEOUT_EN
    // Unit never answers: watchdog aborts without a result.
    begin
      int k = 0;
      dp_hold = 1'b1;
      do_start(7);
      send_chunk(build_chunk(0, 7, 1'b1), build_chunk(0, 7, 1'b0));
      while (!timeout_err && k < 200) begin
        if (bus.result_valid) k = 1000;
        @(negedge clk);
        k++;
      end
      check("timeout_latency", k, 65);
      check("timeout_busy", bus.busy, 0);
      check("timeout_no_result", bus.result_valid, 0);
      @(negedge clk);
      check("timeout_pulse", timeout_err, 0);
      check("timeout_busy_next", bus.busy, 0);
      dp_hold = 1'b0;
    end
`endif

    // Random ops against an integer-sum reference.
    for (int t = 0; t < 10; t++) begin
      n = (t == 9) ? int'($urandom_range(257, VMAX)) : int'($urandom_range(1, 60));
      sum = 0;
      for (int k = 0; k < VMAX; k++) begin
        va[k] = int'($urandom_range(0, 16)) - 8;
        vb[k] = int'($urandom_range(0, 16)) - 8;
        if (k < n && k < MAX_LEN) sum += va[k] * vb[k];
      end
      run_op(n, 3, res);
      check($sformatf("rand%0d_len%0d", t, n), res, i2f(sum));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
